// File: rtl/idli_ctl_m.sv
// ---------------------------------------------------------------------------
// idli_ctl_m : core sync / control block
//
// Owns the free-running 2-bit slice counter shared by the SQI, EX, UTX and
// URX blocks, and sequences core bring-up:
//   RESET -> WAIT (power-up delay) -> INIT (SQI memory init) -> RUN <-> HALT.
// Every state change is decided on a slice-boundary edge (ctr==3), so each
// instruction starts at ctr==0.
//
// Parameters
//   WAIT_CYCLES  gck cycles to wait after reset before SQI init (>=1)
//   SYNC_STAGES  synchroniser depth on the async resume pin (>=2)
//
// Ports
//   i_top_gck        in   1  core clock
//   i_top_rst_n      in   1  asynchronous active-low reset
//   o_ctl_ctr        out  2  slice counter
//   i_ctl_init_done  in   1  SQI finished memory init (level)
//   o_ctl_init       out  1  request SQI memory init sequence
//   i_ctl_halt       in   1  EX halt request, sampled at ctr==3
//   i_ctl_resume     in   1  external resume pin, async, rising-edge
//   i_ctl_ex_stall   in   1  EX stall
//   o_ctl_run        out  1  core may fetch/execute
//   o_ctl_stall      out  1  stall to SQI = !run | ex_stall
//   o_ctl_state      out  3  current FSM state (debug)
// ---------------------------------------------------------------------------
module idli_ctl_m #(
  parameter int WAIT_CYCLES = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_top_gck,
  input  logic       i_top_rst_n,
  output logic [1:0] o_ctl_ctr,
  input  logic       i_ctl_init_done,
  output logic       o_ctl_init,
  input  logic       i_ctl_halt,
  input  logic       i_ctl_resume,
  input  logic       i_ctl_ex_stall,
  output logic       o_ctl_run,
  output logic       o_ctl_stall,
  output logic [2:0] o_ctl_state
);

  localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_WAIT  = 3'd1,
    ST_INIT  = 3'd2,
    ST_RUN   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  state_t                   state_r;
  logic [1:0]               ctr_r;
  logic [WAIT_W-1:0]        wait_r;
  logic [SYNC_STAGES-1:0]   resume_sync_r;
  logic                     resume_prev_r;
  logic                     resume_pend_r;
  logic                     init_r;
  logic                     run_r;

  logic                     slice_end_s;
  logic                     resume_rise_s;

  // Last slice of the instruction: the only edge on which state may move.
  assign slice_end_s   = (ctr_r == 2'd3);
  // Rising edge seen between the last sync stage and the extra history flop.
  assign resume_rise_s = resume_sync_r[SYNC_STAGES-1] & ~resume_prev_r;

  // Free-running slice counter; wraps 3->0 and never stalls.
  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      ctr_r <= 2'd0;
    end else begin
      ctr_r <= ctr_r + 2'd1;
    end
  end

  // Resume pin synchroniser plus one history flop for edge detection.
  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      resume_sync_r <= '0;
      resume_prev_r <= 1'b0;
    end else begin
      resume_sync_r <= {resume_sync_r[SYNC_STAGES-2:0], i_ctl_resume};
      resume_prev_r <= resume_sync_r[SYNC_STAGES-1];
    end
  end

  // Bring-up / run-halt sequencer with registered init and run outputs.
  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      state_r       <= ST_RESET;
      wait_r        <= '0;
      resume_pend_r <= 1'b0;
      init_r        <= 1'b0;
      run_r         <= 1'b0;
    end else begin
      case (state_r)
        ST_RESET: begin
          state_r       <= ST_WAIT;
          wait_r        <= WAIT_LOAD;
          resume_pend_r <= 1'b0;
          init_r        <= 1'b0;
          run_r         <= 1'b0;
        end

        ST_WAIT: begin
          // Saturating countdown; exit waits for both zero and a slice end.
          if (wait_r != '0) begin
            wait_r <= wait_r - WAIT_W'(1);
          end else begin
            wait_r <= wait_r;
          end
          resume_pend_r <= 1'b0;
          run_r         <= 1'b0;
          if ((wait_r == '0) && slice_end_s) begin
            state_r <= ST_INIT;
            init_r  <= 1'b1;
          end else begin
            state_r <= ST_WAIT;
            init_r  <= 1'b0;
          end
        end

        ST_INIT: begin
          wait_r        <= wait_r;
          resume_pend_r <= 1'b0;
          if (i_ctl_init_done && slice_end_s) begin
            state_r <= ST_RUN;
            init_r  <= 1'b0;
            run_r   <= 1'b1;
          end else begin
            state_r <= ST_INIT;
            init_r  <= 1'b1;
            run_r   <= 1'b0;
          end
        end

        ST_RUN: begin
          // Resume edges seen while running are dropped, so a halt taken
          // on the same edge as a resume edge stays halted.
          wait_r        <= wait_r;
          resume_pend_r <= 1'b0;
          init_r        <= 1'b0;
          if (i_ctl_halt && slice_end_s) begin
            state_r <= ST_HALT;
            run_r   <= 1'b0;
          end else begin
            state_r <= ST_RUN;
            run_r   <= 1'b1;
          end
        end

        ST_HALT: begin
          // Only an already-registered pend can resume, so an edge arriving
          // on a slice-end edge waits for the following slice end.
          wait_r <= wait_r;
          init_r <= 1'b0;
          if (resume_pend_r && slice_end_s) begin
            state_r       <= ST_RUN;
            run_r         <= 1'b1;
            resume_pend_r <= 1'b0;
          end else if (resume_rise_s) begin
            state_r       <= ST_HALT;
            run_r         <= 1'b0;
            resume_pend_r <= 1'b1;
          end else begin
            state_r       <= ST_HALT;
            run_r         <= 1'b0;
            resume_pend_r <= resume_pend_r;
          end
        end

        default: begin
          // Unused encodings 5-7 fall back to RESET.
          state_r       <= ST_RESET;
          wait_r        <= '0;
          resume_pend_r <= 1'b0;
          init_r        <= 1'b0;
          run_r         <= 1'b0;
        end
      endcase
    end
  end

  assign o_ctl_ctr   = ctr_r;
  assign o_ctl_init  = init_r;
  assign o_ctl_run   = run_r;
  assign o_ctl_state = state_r;
  // The only input-to-output combinational path in the block.
  assign o_ctl_stall = ~run_r | i_ctl_ex_stall;

endmodule
